freq_bcd_convert: RTL and testbench

- Downstream consumer of the frequency meter's 32-bit Frequency count.
- Converts each new stable count to packed BCD digits for the seven-segment scan stage, using a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- Reports overflow when the count exceeds the displayable range.

---
 rtl/freq_disp_pkg.sv | 28 ++
 rtl/bcd_add3_column.sv | 20 ++
 rtl/freq_bcd_convert.sv | 98 +++++++++
 tb/tb_freq_bcd_convert.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display path.
// BCD sizing helpers used by the converter and its add-3 column.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int DIGITS_DEF = 8;

  // ceil(w * log10(2)) decimal digits hold any w-bit value
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [63:0] max_display(input int d);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < d; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam int BCD_WORK_DIGITS = bcd_digits(32);
  localparam logic [63:0] MAX_DISPLAY = max_display(DIGITS_DEF);

endpackage

// File: rtl/bcd_add3_column.sv
// Double-dabble correction: every digit >= 5 gets +3 before the shift.
// Purely combinational across the whole working register.
module bcd_add3_column
  import freq_disp_pkg::*;
#(
  parameter int N = BCD_WORK_DIGITS
) (
  input  logic [4*N-1:0] din,
  output logic [4*N-1:0] dout
);

  always_comb begin
    dout = din;
    for (int i = 0; i < N; i++) begin
      if (din[4*i +: 4] >= 4'd5)
        dout[4*i +: 4] = din[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/freq_bcd_convert.sv
// Stable-count sampler plus bit-serial binary-to-BCD converter.
// Display registers only change on the Valid pulse.
module freq_bcd_convert
  import freq_disp_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int IN_W   = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [IN_W-1:0]       Frequency,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Valid,
  output logic                  Busy,
  output logic                  Overflow
);

  localparam int WD = bcd_digits(IN_W);
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [63:0] MAXV = max_display(DIGITS);

  state_t state, state_next;

  logic [IN_W-1:0] s1, s2, last, work;
  logic [4*WD-1:0] bcd_work, adj;
  logic [CW-1:0]   bit_cnt;
  logic            ovf_hold;
  logic            candidate;

  assign candidate = (s1 == s2) && (s2 != last);

  bcd_add3_column #(.N(WD)) u_add3 (
    .din  (bcd_work),
    .dout (adj)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (candidate) state_next = CONV;
      CONV: if (bit_cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1       <= '0;
      s2       <= '0;
      last     <= '0;
      work     <= '0;
      bcd_work <= '0;
      bit_cnt  <= '0;
      ovf_hold <= 1'b0;
      Bcd      <= '0;
      Valid    <= 1'b0;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      s1    <= Frequency;
      s2    <= s1;
      Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (candidate) begin
            work     <= s2;
            last     <= s2;
            bcd_work <= '0;
            bit_cnt  <= CW'(IN_W - 1);
            Busy     <= 1'b1;
            ovf_hold <= 64'(s2) > MAXV;
          end
        end
        CONV: begin
          bcd_work <= (adj << 1)
                    | {{(4*WD-1){1'b0}}, work[IN_W-1]};
          work     <= work << 1;
          bit_cnt  <= bit_cnt - 1'b1;
        end
        DONE: begin
          Bcd      <= ovf_hold ? {DIGITS{4'h9}}
                               : bcd_work[4*DIGITS-1:0];
          Overflow <= ovf_hold;
          Valid    <= 1'b1;
          Busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_bcd_convert.sv
// Directed bench: DIGITS=8 and DIGITS=10 instances on one clock.
// Expected BCD values are hand-computed constants.
module tb_freq_bcd_convert;

  logic        clk;
  logic        rst_n;
  logic [31:0] f8, f10;
  logic [31:0] bcd8;
  logic [39:0] bcd10;
  logic        v8, busy8, ovf8;
  logic        v10, busy10, ovf10;

  int passed = 0;
  int total  = 0;

  freq_bcd_convert #(.DIGITS(8), .IN_W(32)) dut8 (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Frequency (f8),
    .Bcd       (bcd8),
    .Valid     (v8),
    .Busy      (busy8),
    .Overflow  (ovf8)
  );

  freq_bcd_convert #(.DIGITS(10), .IN_W(32)) dut10 (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Frequency (f10),
    .Bcd       (bcd10),
    .Valid     (v10),
    .Busy      (busy10),
    .Overflow  (ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit wide, input int max,
                            output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(wide ? v10 : v8) && n < max);
  endtask

  task automatic test_reset;
    int pulses;
    int busy_seen;
    rst_n = 1'b0;
    f8 = '0;
    f10 = '0;
    repeat (3) tick();
    total++;
    if ({bcd8, v8, busy8, ovf8} !== 35'd0)
      $display("FAIL reset_outputs: got bcd=%h v=%b b=%b o=%b want 0",
               bcd8, v8, busy8, ovf8);
    else passed++;
    rst_n = 1'b1;
    pulses = 0;
    busy_seen = 0;
    repeat (100) begin
      tick();
      if (v8 || v10) pulses++;
      if (busy8 || busy10) busy_seen++;
    end
    total++;
    if (pulses !== 0)
      $display("FAIL zero_no_valid: got %0d pulses want 0", pulses);
    else passed++;
    total++;
    if (busy_seen !== 0 || bcd8 !== 32'd0 || ovf8 !== 1'b0)
      $display("FAIL zero_idle: busy=%0d bcd=%h ovf=%b want 0/0/0",
               busy_seen, bcd8, ovf8);
    else passed++;
  endtask

  task automatic test_latency;
    int n;
    int busy_cnt;
    f8 = 32'd1_000_000;
    n = 0;
    busy_cnt = 0;
    do begin
      tick();
      n++;
      if (busy8) busy_cnt++;
    end while (!v8 && n < 60);
    total++;
    if (n !== 36 || v8 !== 1'b1)
      $display("FAIL latency: got %0d cycles valid=%b want 36", n, v8);
    else passed++;
    total++;
    if (bcd8 !== 32'h01000000 || ovf8 !== 1'b0)
      $display("FAIL bcd_1m: got %h ovf=%b want 01000000 ovf=0",
               bcd8, ovf8);
    else passed++;
    total++;
    if (busy_cnt !== 33)
      $display("FAIL busy_len: got %0d want 33", busy_cnt);
    else passed++;
    tick();
    total++;
    if (v8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL valid_pulse: got v=%b busy=%b want 0/0", v8, busy8);
    else passed++;
  endtask

  task automatic test_overflow;
    int n;
    f8 = 32'd99_999_999;
    wait_valid(1'b0, 60, n);
    total++;
    if (v8 !== 1'b1 || bcd8 !== 32'h99999999 || ovf8 !== 1'b0)
      $display("FAIL max_fit: got v=%b bcd=%h ovf=%b want 1/99999999/0",
               v8, bcd8, ovf8);
    else passed++;
    f8 = 32'd100_000_000;
    wait_valid(1'b0, 60, n);
    total++;
    if (v8 !== 1'b1 || bcd8 !== 32'h99999999 || ovf8 !== 1'b1)
      $display("FAIL overflow: got v=%b bcd=%h ovf=%b want 1/99999999/1",
               v8, bcd8, ovf8);
    else passed++;
  endtask

  task automatic test_wide;
    int n;
    f10 = 32'hFFFF_FFFF;
    wait_valid(1'b1, 60, n);
    total++;
    if (v10 !== 1'b1 || bcd10 !== 40'h4294967295 || ovf10 !== 1'b0)
      $display("FAIL wide_max: got v=%b bcd=%h ovf=%b want 1/4294967295/0",
               v10, bcd10, ovf10);
    else passed++;
  endtask

  task automatic test_change_during_conv;
    int n;
    int pulses;
    f8 = 32'd12345;
    repeat (12) tick();
    f8 = 32'd678;
    wait_valid(1'b0, 40, n);
    total++;
    if (n !== 24 || v8 !== 1'b1 || bcd8 !== 32'h00012345 || ovf8 !== 1'b0)
      $display("FAIL first_of_two: got n=%0d v=%b bcd=%h ovf=%b want 24/1/00012345/0",
               n, v8, bcd8, ovf8);
    else passed++;
    wait_valid(1'b0, 50, n);
    total++;
    if (v8 !== 1'b1 || bcd8 !== 32'h00000678)
      $display("FAIL second_of_two: got v=%b bcd=%h want 1/00000678",
               v8, bcd8);
    else passed++;
    repeat (5) tick();
    f8 = 32'd4321;
    tick();
    f8 = 32'd678;
    pulses = 0;
    repeat (50) begin
      tick();
      if (v8) pulses++;
    end
    total++;
    if (pulses !== 0 || bcd8 !== 32'h00000678)
      $display("FAIL glitch: got %0d pulses bcd=%h want 0/00000678",
               pulses, bcd8);
    else passed++;
  endtask

  task automatic test_reset_mid_conv;
    int n;
    int pulses;
    f8 = 32'd555;
    repeat (17) tick();
    total++;
    if (busy8 !== 1'b1)
      $display("FAIL busy_mid_conv: got %b want 1", busy8);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bcd8, v8, busy8, ovf8} !== 35'd0)
      $display("FAIL abort_outputs: got bcd=%h v=%b b=%b o=%b want 0",
               bcd8, v8, busy8, ovf8);
    else passed++;
    pulses = 0;
    repeat (3) begin
      tick();
      if (v8) pulses++;
    end
    rst_n = 1'b1;
    wait_valid(1'b0, 60, n);
    total++;
    if (pulses !== 0 || n !== 36 || v8 !== 1'b1 || bcd8 !== 32'h00000555)
      $display("FAIL reconvert: got pulses=%0d n=%0d v=%b bcd=%h want 0/36/1/00000555",
               pulses, n, v8, bcd8);
    else passed++;
  endtask

  task automatic test_repeat;
    int pulses;
    tick();
    f8 = 32'd555;
    pulses = 0;
    repeat (50) begin
      tick();
      if (v8) pulses++;
    end
    total++;
    if (pulses !== 0 || bcd8 !== 32'h00000555 || busy8 !== 1'b0)
      $display("FAIL repeat_value: got %0d pulses bcd=%h busy=%b want 0/00000555/0",
               pulses, bcd8, busy8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_wide();
    test_change_during_conv();
    test_reset_mid_conv();
    test_repeat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
